// File: rtl/char_pkg.sv
// Shared character class codes and ASCII boundaries.
// Used by the FIFO and by the downstream char detector.
package char_pkg;

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'b00,
        CLS_DIGIT  = 2'b01,
        CLS_LETTER = 2'b10,
        CLS_SPACE  = 2'b11
    } char_class_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_UC_A  = 8'h41;
    localparam logic [7:0] ASCII_UC_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int CHAR_W  = 8;
    localparam int CLASS_W = 2;
    localparam int ENTRY_W = CHAR_W + CLASS_W;

endpackage

// File: rtl/char_classify.sv
// Combinational ASCII classifier: digit, letter, space or other.
// Shared with the char detector so both agree on class codes.
module char_classify
    import char_pkg::*;
(
    input  logic [7:0] ch,
    output logic [1:0] cls
);

    logic is_digit;
    logic is_upper;
    logic is_lower;
    logic is_space;

    assign is_digit = (ch >= ASCII_0) && (ch <= ASCII_9);
    assign is_upper = (ch >= ASCII_UC_A) && (ch <= ASCII_UC_Z);
    assign is_lower = (ch >= ASCII_LC_A) && (ch <= ASCII_LC_Z);
    assign is_space = (ch == ASCII_SPACE);

    always_comb begin
        cls = CLS_OTHER;
        unique case (1'b1)
            is_digit:            cls = CLS_DIGIT;
            is_upper, is_lower:  cls = CLS_LETTER;
            is_space:            cls = CLS_SPACE;
            default:             cls = CLS_OTHER;
        endcase
    end

endmodule

// File: rtl/char_class_fifo.sv
// Show-ahead FIFO that tags each character with its class on write.
// Flush clears all entries synchronously and wins over push/pop.
module char_class_fifo
    import char_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [7:0]                 in_char,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_char,
    output logic [1:0]                 out_class,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [1:0]         in_class;
    logic               push;
    logic               pop;

    char_classify u_classify (
        .ch  (in_char),
        .cls (in_class)
    );

    // Ready depends only on occupancy, never on the pop side.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_char  = mem[rd_ptr][CHAR_W-1:0];
    assign out_class = mem[rd_ptr][ENTRY_W-1:CHAR_W];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_class, in_char};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_char_class_fifo.sv
// Directed bench for char_class_fifo with a scoreboard ordering run.
module tb_char_class_fifo;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_char;
    logic [1:0] out_class;
    logic       out_ready;
    logic [2:0] count;

    int checks;
    int errors;

    char_class_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_class (out_class),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_class(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return 2'b01;
        if (c >= 8'h41 && c <= 8'h5A) return 2'b10;
        if (c >= 8'h61 && c <= 8'h7A) return 2'b10;
        if (c == 8'h20) return 2'b11;
        return 2'b00;
    endfunction

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d in_ready=%b out_valid=%b want 0/1/0",
                     count, in_ready, out_valid);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: count=%0d out_valid=%b want 0/0",
                     count, out_valid);
        end
    endtask

    task automatic test_push_hold();
        logic [7:0] s [3];
        logic [1:0] c [3];
        s = '{8'h41, 8'h62, 8'h37};
        c = '{2'b10, 2'b10, 2'b01};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_char  = s[i];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || out_char !== 8'h41 || out_class !== 2'b10) begin
            errors++;
            $display("FAIL push_hold: count=%0d char=%h cls=%b want 3/41/10",
                     count, out_char, out_class);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_char !== s[i] || out_class !== c[i]) begin
                errors++;
                $display("FAIL push_hold_drain%0d: v=%b char=%h cls=%b want 1/%h/%b",
                         i, out_valid, out_char, out_class, s[i], c[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL push_hold_empty: v=%b count=%0d want 0/0",
                     out_valid, count);
        end
    endtask

    task automatic test_full();
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_char  = 8'h30 + 8'(i);
            tick();
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        in_char   = 8'h78;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || out_char !== 8'h31) begin
            errors++;
            $display("FAIL full_refuse: count=%0d char=%h want 3/31",
                     count, out_char);
        end
        tick();
        tick();
        checks++;
        if (out_char !== 8'h33 || count !== 3'd1) begin
            errors++;
            $display("FAIL full_tail: char=%h count=%0d want 33/1",
                     out_char, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_no_x: out_valid=%b char=%h want 0",
                     out_valid, out_char);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] s [4];
        logic [1:0] c [4];
        s = '{8'h61, 8'h31, 8'h20, 8'h3F};
        c = '{2'b10, 2'b01, 2'b11, 2'b00};
        do_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_char  = s[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_char !== s[i] ||
                out_class !== c[i] || count !== 3'd1) begin
                errors++;
                $display("FAIL stream%0d: v=%b char=%h cls=%b cnt=%0d want 1/%h/%b/1",
                         i, out_valid, out_char, out_class, count, s[i], c[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = 8'h4B;
        tick();
        tick();
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL flush_pre: count=%0d want 2", count);
        end
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: count=%0d out_valid=%b want 0/0",
                     count, out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_char  = 8'h61 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL async_pre: count=%0d want 3", count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: count=%0d v=%b rdy=%b want 0/0/1",
                     count, out_valid, in_ready);
        end
        #2 reset = 1'b0;
        tick();
        in_valid = 1'b1;
        in_char  = 8'h51;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || out_char !== 8'h51 || out_class !== 2'b10) begin
            errors++;
            $display("FAIL async_new_head: count=%0d char=%h cls=%b want 1/51/10",
                     count, out_char, out_class);
        end
        do_flush();
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        logic [7:0] nxt;
        logic [7:0] exp;
        logic       push;
        logic       pop;
        int         sb_err;
        int         pushes;
        sb_err = 0;
        pushes = 0;
        nxt    = 8'h28;
        do_flush();
        for (int n = 0; n < 60; n++) begin
            if (n < 48) begin
                in_valid  = (n % 3) != 2;
                out_ready = (n % 4) != 0;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_char = nxt;
            push = in_valid && in_ready;
            pop  = out_valid && out_ready;
            if (pop) begin
                exp = q.pop_front();
                checks++;
                if (out_char !== exp || out_class !== ref_class(exp)) begin
                    errors++;
                    sb_err++;
                    $display("FAIL wrap_data%0d: char=%h cls=%b want %h/%b",
                             n, out_char, out_class, exp, ref_class(exp));
                end
            end
            if (push) begin
                q.push_back(nxt);
                nxt = nxt + 8'd5;
                pushes++;
            end
            tick();
            checks++;
            if (int'(count) !== q.size()) begin
                errors++;
                sb_err++;
                $display("FAIL wrap_count%0d: count=%0d want %0d",
                         n, count, q.size());
            end
        end
        checks++;
        if (pushes <= 8 || q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_final: pushes=%0d left=%0d v=%b sb_err=%0d",
                     pushes, q.size(), out_valid, sb_err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_push_hold();
        test_full();
        test_stream();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
